// File: rtl/execute_alu_cc.sv
// Y86-64 SEQ execute stage: computes valE, keeps the {ZF,SF,OF} condition codes
// and evaluates cmovXX/jXX conditions, with all results registered one cycle later.
module execute_alu_cc #(
  parameter int unsigned W          = 64,
  parameter int unsigned STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  output logic [3:0]   out_icode,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         halted,
  output logic         func_error,
  output logic         instr_error
);

  typedef enum logic [2:0] {OP_ZERO, OP_ADD, OP_SUB, OP_AND, OP_XOR} alu_op_e;

  logic         accept_c;
  logic         instr_err_c;
  logic         func_err_c;
  logic         is_cond_c;
  logic         cond_c;
  logic         cc_we_c;
  logic         halt_c;
  alu_op_e      op_c;
  logic [W-1:0] alu_a_c;
  logic [W-1:0] alu_b_c;
  logic [W-1:0] sum_c;
  logic [W-1:0] diff_c;
  logic [W-1:0] e_c;
  logic         of_c;

  // Instruction legality checks
  always_comb begin
    accept_c    = in_valid && !halted;
    instr_err_c = (icode > 4'hB);
    func_err_c  = 1'b0;
    case (icode)
      4'h2, 4'h7: func_err_c = (ifun > 4'd6);
      4'h6:       func_err_c = (ifun > 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
      4'h8, 4'h9, 4'hA, 4'hB: func_err_c = (ifun != 4'd0);
      default:    func_err_c = 1'b0;
    endcase
    is_cond_c = (icode == 4'h2) || (icode == 4'h7);
    cc_we_c   = (icode == 4'h6) && !func_err_c;
    halt_c    = (icode == 4'h0) || instr_err_c;
  end

  // ALU operand and operation selection
  always_comb begin
    alu_a_c = '0;
    alu_b_c = '0;
    op_c    = OP_ZERO;
    case (icode)
      4'h2: begin alu_a_c = valA; op_c = OP_ADD; end
      4'h3: begin alu_a_c = valC; op_c = OP_ADD; end
      4'h4, 4'h5: begin
        alu_a_c = valC;
        alu_b_c = valB;
        op_c    = OP_ADD;
      end
      4'h6: begin
        alu_a_c = valA;
        alu_b_c = valB;
        if (!func_err_c) begin
          case (ifun[1:0])
            2'd0:    op_c = OP_ADD;
            2'd1:    op_c = OP_SUB;
            2'd2:    op_c = OP_AND;
            default: op_c = OP_XOR;
          endcase
        end
      end
      4'h8, 4'hA: begin
        alu_a_c = W'(STACK_STEP);
        alu_b_c = valB;
        op_c    = OP_SUB;
      end
      4'h9, 4'hB: begin
        alu_a_c = W'(STACK_STEP);
        alu_b_c = valB;
        op_c    = OP_ADD;
      end
      default: op_c = OP_ZERO;
    endcase
  end

  // ALU result and signed overflow
  always_comb begin
    sum_c  = alu_b_c + alu_a_c;
    diff_c = alu_b_c - alu_a_c;
    e_c    = '0;
    of_c   = 1'b0;
    case (op_c)
      OP_ADD: begin
        e_c  = sum_c;
        of_c = (alu_a_c[W-1] == alu_b_c[W-1]) && (sum_c[W-1] != alu_a_c[W-1]);
      end
      OP_SUB: begin
        e_c  = diff_c;
        of_c = (alu_a_c[W-1] != alu_b_c[W-1]) && (diff_c[W-1] != alu_b_c[W-1]);
      end
      OP_AND:  e_c = alu_b_c & alu_a_c;
      OP_XOR:  e_c = alu_b_c ^ alu_a_c;
      default: e_c = '0;
    endcase
  end

  // Condition evaluated on the CC value held before this edge
  always_comb begin
    cond_c = 1'b0;
    case (ifun)
      4'd0:    cond_c = 1'b1;
      4'd1:    cond_c = (cc[1] ^ cc[0]) | cc[2];
      4'd2:    cond_c = cc[1] ^ cc[0];
      4'd3:    cond_c = cc[2];
      4'd4:    cond_c = ~cc[2];
      4'd5:    cond_c = ~(cc[1] ^ cc[0]);
      4'd6:    cond_c = ~(cc[1] ^ cc[0]) & ~cc[2];
      default: cond_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_icode   <= 4'h1;
      valE        <= '0;
      cnd         <= 1'b0;
      cc          <= 3'b100;
      halted      <= 1'b0;
      func_error  <= 1'b0;
      instr_error <= 1'b0;
    end else begin
      out_valid <= accept_c;
      if (accept_c) begin
        out_icode   <= icode;
        valE        <= e_c;
        cnd         <= is_cond_c && !func_err_c && cond_c;
        func_error  <= func_err_c;
        instr_error <= instr_err_c;
        if (cc_we_c) cc <= {(e_c == '0), e_c[W-1], of_c};
        if (halt_c) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_execute_alu_cc.sv
// Directed table-driven bench for execute_alu_cc plus reset/halt corner sequences.
module tb_execute_alu_cc;

  localparam int unsigned W = 64;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA, valB, valC;
  logic         out_valid;
  logic [3:0]   out_icode;
  logic [W-1:0] valE;
  logic         cnd;
  logic [2:0]   cc;
  logic         halted;
  logic         func_error;
  logic         instr_error;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        v;
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [63:0] a, b, c;
    logic        e_ov;
    logic [3:0]  e_ic;
    logic [63:0] e_val;
    logic        e_cnd;
    logic [2:0]  e_cc;
    logic        e_halt, e_fe, e_ie;
  } vec_t;

  vec_t vq[$];

  execute_alu_cc #(.W(W), .STACK_STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC), .out_valid(out_valid),
    .out_icode(out_icode), .valE(valE), .cnd(cnd), .cc(cc), .halted(halted),
    .func_error(func_error), .instr_error(instr_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic addv(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic e_ov, input logic [3:0] e_ic, input logic [63:0] e_val,
                      input logic e_cnd, input logic [2:0] e_cc, input logic e_halt,
                      input logic e_fe, input logic e_ie);
    vec_t t;
    t.v = v; t.ic = ic; t.fn = fn; t.a = a; t.b = b; t.c = c;
    t.e_ov = e_ov; t.e_ic = e_ic; t.e_val = e_val; t.e_cnd = e_cnd; t.e_cc = e_cc;
    t.e_halt = e_halt; t.e_fe = e_fe; t.e_ie = e_ie;
    vq.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    in_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
  endtask

  task automatic check_all(input int idx, input logic e_ov, input logic [3:0] e_ic,
                           input logic [63:0] e_val, input logic e_cnd,
                           input logic [2:0] e_cc, input logic e_halt,
                           input logic e_fe, input logic e_ie);
    chk("out_valid", idx, 64'(out_valid), 64'(e_ov));
    chk("out_icode", idx, 64'(out_icode), 64'(e_ic));
    chk("valE", idx, valE, e_val);
    chk("cnd", idx, 64'(cnd), 64'(e_cnd));
    chk("cc", idx, 64'(cc), 64'(e_cc));
    chk("halted", idx, 64'(halted), 64'(e_halt));
    chk("func_error", idx, 64'(func_error), 64'(e_fe));
    chk("instr_error", idx, 64'(instr_error), 64'(e_ie));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h1, 4'h0, '0, '0, '0);

    //   v  ic    fn    valA    valB     valC      ov ic    valE     cnd cc      h  fe ie
    addv(1, 4'h6, 4'h0, MAXP,   64'd1,   64'd0,    1, 4'h6, MINN,    0, 3'b011, 0, 0, 0);
    addv(1, 4'h6, 4'h1, 64'd5,  64'd5,   64'd0,    1, 4'h6, 64'd0,   0, 3'b100, 0, 0, 0);
    addv(1, 4'h7, 4'h3, 64'd0,  64'd0,   64'd0,    1, 4'h7, 64'd0,   1, 3'b100, 0, 0, 0);
    addv(1, 4'h7, 4'h4, 64'd0,  64'd0,   64'd0,    1, 4'h7, 64'd0,   0, 3'b100, 0, 0, 0);
    addv(1, 4'hA, 4'h0, 64'd0,  64'd1023,64'd0,    1, 4'hA, 64'd1015,0, 3'b100, 0, 0, 0);
    addv(1, 4'hB, 4'h0, 64'd0,  64'd1015,64'd0,    1, 4'hB, 64'd1023,0, 3'b100, 0, 0, 0);
    addv(1, 4'h5, 4'h0, 64'd0,  64'd16,  64'd8,    1, 4'h5, 64'd24,  0, 3'b100, 0, 0, 0);
    addv(0, 4'h6, 4'h1, 64'd9,  64'd3,   64'd7,    0, 4'h5, 64'd24,  0, 3'b100, 0, 0, 0);
    addv(0, 4'h7, 4'h0, 64'd1,  64'd2,   64'd3,    0, 4'h5, 64'd24,  0, 3'b100, 0, 0, 0);
    addv(0, 4'h6, 4'h0, MAXP,   64'd1,   64'd5,    0, 4'h5, 64'd24,  0, 3'b100, 0, 0, 0);
    addv(1, 4'h6, 4'h1, 64'd1,  64'd0,   64'd0,    1, 4'h6, ONES,    0, 3'b010, 0, 0, 0);
    addv(1, 4'h7, 4'h2, 64'd0,  64'd0,   64'd0,    1, 4'h7, 64'd0,   1, 3'b010, 0, 0, 0);
    addv(1, 4'h2, 4'h6, 64'h55, 64'd0,   64'd0,    1, 4'h2, 64'h55,  0, 3'b010, 0, 0, 0);
    addv(1, 4'h6, 4'h1, 64'd1,  MINN,    64'd0,    1, 4'h6, MAXP,    0, 3'b001, 0, 0, 0);
    addv(1, 4'h7, 4'h5, 64'd0,  64'd0,   64'd0,    1, 4'h7, 64'd0,   0, 3'b001, 0, 0, 0);
    addv(1, 4'h7, 4'h1, 64'd0,  64'd0,   64'd0,    1, 4'h7, 64'd0,   1, 3'b001, 0, 0, 0);
    addv(1, 4'h6, 4'h4, 64'd3,  64'd4,   64'd0,    1, 4'h6, 64'd0,   0, 3'b001, 0, 1, 0);
    addv(1, 4'h2, 4'h7, 64'h99, 64'd0,   64'd0,    1, 4'h2, 64'h99,  0, 3'b001, 0, 1, 0);
    addv(1, 4'h1, 4'h0, 64'd0,  64'd0,   64'd0,    1, 4'h1, 64'd0,   0, 3'b001, 0, 0, 0);
    addv(1, 4'h6, 4'h2, 64'hF0, 64'h0F,  64'd0,    1, 4'h6, 64'd0,   0, 3'b100, 0, 0, 0);
    addv(1, 4'h6, 4'h3, 64'hFF, 64'h0F,  64'd0,    1, 4'h6, 64'hF0,  0, 3'b000, 0, 0, 0);
    addv(1, 4'h3, 4'h0, 64'd0,  64'd0,   64'h1234, 1, 4'h3, 64'h1234,0, 3'b000, 0, 0, 0);
    addv(1, 4'h8, 4'h0, 64'd0,  64'd64,  64'd0,    1, 4'h8, 64'd56,  0, 3'b000, 0, 0, 0);
    addv(1, 4'h9, 4'h0, 64'd0,  64'd56,  64'd0,    1, 4'h9, 64'd64,  0, 3'b000, 0, 0, 0);
    addv(1, 4'h7, 4'h0, 64'd0,  64'd0,   64'd0,    1, 4'h7, 64'd0,   1, 3'b000, 0, 0, 0);
    addv(1, 4'hC, 4'h0, 64'd0,  64'd0,   64'd0,    1, 4'hC, 64'd0,   0, 3'b000, 1, 0, 1);
    addv(1, 4'h6, 4'h0, 64'd1,  64'd1,   64'd0,    0, 4'hC, 64'd0,   0, 3'b000, 1, 0, 1);

    // Reset values
    #12;
    check_all(100, 0, 4'h1, 64'd0, 0, 3'b100, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].v, vq[i].ic, vq[i].fn, vq[i].a, vq[i].b, vq[i].c);
      @(posedge clk);
      #1;
      check_all(i, vq[i].e_ov, vq[i].e_ic, vq[i].e_val, vq[i].e_cnd, vq[i].e_cc,
                vq[i].e_halt, vq[i].e_fe, vq[i].e_ie);
    end

    // Halt freezes state; a following add is ignored
    drive(1'b0, 4'h1, 4'h0, '0, '0, '0);
    do_reset();
    drive(1'b1, 4'h0, 4'h0, '0, '0, '0);
    @(posedge clk); #1;
    check_all(200, 1, 4'h0, 64'd0, 0, 3'b100, 1, 0, 0);
    @(negedge clk);
    drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, '0);
    @(posedge clk); #1;
    check_all(201, 0, 4'h0, 64'd0, 0, 3'b100, 1, 0, 0);

    // Async reset mid-cycle clears immediately
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all(202, 0, 4'h1, 64'd0, 0, 3'b100, 0, 0, 0);

    // Reset held across an edge with a CC-changing add pending
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'h6, 4'h0, MAXP, 64'd1, '0);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all(203, 0, 4'h1, 64'd0, 0, 3'b100, 0, 0, 0);

    // Normal operation resumes after reset
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'h6, 4'h0, 64'd2, 64'd3, '0);
    @(posedge clk); #1;
    check_all(204, 1, 4'h6, 64'd5, 0, 3'b000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_alu_cc.md
Name: execute_alu_cc

Overview:
- Execute stage of the Y86-64 SEQ datapath. Sits directly downstream of the decode/register-file block.
- Consumes decoded icode/ifun and valA/valB from the register file, plus valC from fetch.
- Computes valE, maintains the condition-code register (ZF/SF/OF) and evaluates the cmovXX/jXX condition.
- Results are registered with one-cycle latency and returned to writeback (valE) and the PC-select logic (cnd).

Parameters:
- W, 64, datapath width in bits.
- STACK_STEP, 8, byte adjustment applied to %rsp for call/ret/push/pop.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- valA  in  W  register operand A from decode.
- valB  in  W  register operand B from decode.
- valC  in  W  constant from fetch.
- out_valid  out  1  registered result valid.
- out_icode  out  4  registered icode pass-through.
- valE  out  W  registered ALU result.
- cnd  out  1  registered condition result.
- cc  out  3  current CC register {ZF,SF,OF}.
- halted  out  1  sticky halt status.
- func_error  out  1  registered: bad ifun for the accepted icode.
- instr_error  out  1  registered: icode greater than 4'hB.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_icode=4'h1, valE=0, cnd=0, halted=0, func_error=0, instr_error=0.
  - cc={ZF=1,SF=0,OF=0}.
- Accept: an instruction is accepted on a posedge when in_valid=1 and halted=0. Outputs update on that edge; latency is 1 cycle.
- Non-accept cycles: out_valid=0. Every other output holds its last value.
- ALU inputs (aluA, aluB) and operation, selected per icode:
  - 2 (rrmovq/cmovXX): valA+0.
  - 3 (irmovq): valC+0.
  - 4 and 5 (rmmovq, mrmovq): valB+valC.
  - 6 (OPq): ifun 0 → valB+valA; ifun 1 → valB−valA; ifun 2 → valB&valA; ifun 3 → valB^valA.
  - 8 and A (call, pushq): valB−STACK_STEP.
  - 9 and B (ret, popq): valB+STACK_STEP.
  - 0, 1 and 7 (halt, nop, jXX): valE=0.
- Arithmetic is modulo 2^W and carry is discarded. OF rules:
  - add: OF = (A[W-1]==B[W-1]) && (E[W-1]!=A[W-1]).
  - sub: OF = (A[W-1]!=B[W-1]) && (E[W-1]!=B[W-1]).
  - and, xor: OF=0.
- CC update:
  - Only on an accepted OPq with ifun ≤ 3.
  - ZF = (E==0), SF = E[W-1], OF as above.
  - All other instructions leave cc unchanged.
- Condition evaluation:
  - For icode 2 and 7, cnd is evaluated on the CC value held before this edge, by ifun:
    - 0: 1.
    - 1: (SF^OF)|ZF.
    - 2: SF^OF.
    - 3: ZF.
    - 4: ~ZF.
    - 5: ~(SF^OF).
    - 6: ~(SF^OF)&~ZF.
  - For all other icodes cnd=0.
  - Back-to-back: an OPq followed by a jXX on the next accepted cycle sees the CC written by the OPq.
- func_error:
  - Set to 1 when icode 2 or 7 has ifun>6, icode 6 has ifun>3, or any other legal icode has ifun≠0.
  - On an OPq with func_error, cc is not updated and valE=0.
  - On a cmov/jXX with func_error, cnd=0.
- instr_error:
  - Set to 1 when icode>4'hB. Then valE=0, cnd=0, cc unchanged.
  - Also sets halted, same as a halt.
- Halt:
  - An accepted icode 0 sets halted=1 and out_valid=1 on that edge.
  - After that, all inputs are ignored and outputs frozen until rst_n is asserted.
- Reset mid-operation: asserting rst_n overrides any in-flight accept. No partial CC update may survive.

Test Plan:
- Reset, then OPq add (icode 6, ifun 0), valA=64'h7FFF_FFFF_FFFF_FFFF, valB=1 → next cycle valE=64'h8000_0000_0000_0000, cc={0,1,1}, out_valid=1.
- OPq sub, valA=5, valB=5 → valE=0, cc={1,0,0}. Next cycle jXX ifun 3 (je) → cnd=1; then jXX ifun 4 (jne) → cnd=0; cc unchanged.
- pushq, valB=1023 → valE=1015. popq, valB=1015 → valE=1023. mrmovq, valB=16, valC=8 → valE=24. cc stays at reset value {1,0,0} throughout.
- OPq with ifun=4, valA=3, valB=4 → func_error=1, valE=0, cc unchanged. Then icode 4'hC → instr_error=1, halted=1; subsequent in_valid=1 produces out_valid=0.
- halt (icode 0), then addq valA=1, valB=1 → halted=1, valE frozen at 0, cc frozen. Asserting rst_n=0 mid-cycle → immediate return to reset values.
- in_valid=0 with changing inputs for 3 cycles → out_valid=0, valE/cc/cnd hold their prior values.
